// File: rtl/irq_vector_ctrl_if.sv
// Redirect/interrupt bundle between the interrupt sources, the vector controller
// and the PC-select stage.
interface irq_vector_ctrl_if #(
   parameter int NIRQ = 4
);
   logic [NIRQ-1:0] irq_in;
   logic [NIRQ-1:0] irq_mask;
   logic            irq_done;
   logic            INT;
   logic [31:0]     entryPoint;
   logic            in_service;
   logic [3:0]      active_id;
   logic [NIRQ-1:0] pending;

   modport master (
      output irq_in, irq_mask, irq_done,
      input  INT, entryPoint, in_service, active_id, pending
   );

   modport slave (
      input  irq_in, irq_mask, irq_done,
      output INT, entryPoint, in_service, active_id, pending
   );
endinterface

// File: rtl/irq_vector_ctrl.sv
// Non-nesting interrupt vector controller: boots the CPU to BOOT_VEC, then turns
// latched edge requests into one-cycle INT/entryPoint redirects, lowest index first.
module irq_vector_ctrl #(
   parameter int          NIRQ       = 4,
   parameter logic [31:0] BOOT_VEC   = 32'h28,
   parameter logic [31:0] VEC_BASE   = 32'h100,
   parameter logic [31:0] VEC_STRIDE = 32'h10
) (
   input  logic                clk,
   input  logic                rst,
   irq_vector_ctrl_if.slave    bus
);

   typedef enum logic [1:0] {BOOT, IDLE, FIRE, SERVICE} state_t;

   state_t          state;
   logic [NIRQ-1:0] prev;
   logic [NIRQ-1:0] rise;
   logic [NIRQ-1:0] eligible;
   logic [NIRQ-1:0] take_mask;
   logic [3:0]      take_id;
   logic [31:0]     take_vec;

   // Lowest-index eligible request wins; take_mask is its one-hot clear mask.
   always_comb begin
      rise      = bus.irq_in & ~prev;
      eligible  = bus.pending & ~bus.irq_mask;
      take_id   = 4'd0;
      take_mask = '0;
      for (int i = NIRQ - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            take_id   = 4'(i);
            take_mask = '0;
            take_mask[i] = 1'b1;
         end
      end
      take_vec = VEC_BASE + ({28'd0, take_id} * VEC_STRIDE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= BOOT;
         bus.INT        <= 1'b1;
         bus.entryPoint <= BOOT_VEC;
         bus.pending    <= '0;
         bus.in_service <= 1'b0;
         bus.active_id  <= 4'd0;
         prev           <= '0;
      end else begin
         prev <= bus.irq_in;
         // A fresh edge on the bit being taken this cycle re-arms it (set wins).
         if (state == IDLE && eligible != '0)
            bus.pending <= (bus.pending & ~take_mask) | rise;
         else
            bus.pending <= bus.pending | rise;

         case (state)
            BOOT: begin
               state   <= IDLE;
               bus.INT <= 1'b0;
            end
            IDLE: begin
               if (eligible != '0) begin
                  state          <= FIRE;
                  bus.INT        <= 1'b1;
                  bus.entryPoint <= take_vec;
                  bus.active_id  <= take_id;
                  bus.in_service <= 1'b1;
               end
            end
            FIRE: begin
               state   <= SERVICE;
               bus.INT <= 1'b0;
            end
            SERVICE: begin
               if (bus.irq_done) begin
                  state          <= IDLE;
                  bus.in_service <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               bus.INT <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Directed bench for irq_vector_ctrl: boot vector, priority, masking, edge
// detection, done handling and mid-service reset, with hand-computed expectations.
module tb_irq_vector_ctrl;

   logic clk;
   logic rst;
   int   testCount;
   int   failCount;

   irq_vector_ctrl_if #(.NIRQ(4)) bus ();

   irq_vector_ctrl #(
      .NIRQ(4), .BOOT_VEC(32'h28), .VEC_BASE(32'h100), .VEC_STRIDE(32'h10)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive inputs, then advance to 1ns past the next rising edge.
   task automatic applyStimulus(input logic [3:0] irqIn, input logic [3:0] irqMask,
                                input logic irqDone);
      bus.irq_in   = irqIn;
      bus.irq_mask = irqMask;
      bus.irq_done = irqDone;
      @(posedge clk);
      #1;
   endtask

   initial begin
      testCount    = 0;
      failCount    = 0;
      rst          = 1'b1;
      bus.irq_in   = '0;
      bus.irq_mask = '0;
      bus.irq_done = 1'b0;

      // Boot: reset held for three cycles, vector visible until the first edge.
      repeat (3) applyStimulus(4'b0000, 4'b0000, 1'b0);
      checkOutput("rst_int", 32'(bus.INT), 32'd1);
      checkOutput("rst_entry", bus.entryPoint, 32'h28);
      checkOutput("rst_pending", 32'(bus.pending), 32'd0);
      checkOutput("rst_in_service", 32'(bus.in_service), 32'd0);
      checkOutput("rst_active_id", 32'(bus.active_id), 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("boot_hold_int", 32'(bus.INT), 32'd1);
      checkOutput("boot_hold_entry", bus.entryPoint, 32'h28);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      checkOutput("boot_exit_int", 32'(bus.INT), 32'd0);
      checkOutput("boot_exit_in_service", 32'(bus.in_service), 32'd0);

      // Single request on irq 2.
      applyStimulus(4'b0100, 4'b0000, 1'b0);
      checkOutput("irq2_pending", 32'(bus.pending), 32'b0100);
      checkOutput("irq2_pre_int", 32'(bus.INT), 32'd0);
      applyStimulus(4'b0100, 4'b0000, 1'b0);
      checkOutput("irq2_fire_int", 32'(bus.INT), 32'd1);
      checkOutput("irq2_entry", bus.entryPoint, 32'h120);
      checkOutput("irq2_active_id", 32'(bus.active_id), 32'd2);
      checkOutput("irq2_pending_clr", 32'(bus.pending), 32'd0);
      checkOutput("irq2_in_service", 32'(bus.in_service), 32'd1);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      checkOutput("irq2_int_pulse_end", 32'(bus.INT), 32'd0);
      checkOutput("irq2_service", 32'(bus.in_service), 32'd1);
      applyStimulus(4'b0000, 4'b0000, 1'b1);
      checkOutput("irq2_done", 32'(bus.in_service), 32'd0);

      // irq 1 and 3 together: 1 first, 3 waits until done.
      applyStimulus(4'b1010, 4'b0000, 1'b0);
      checkOutput("pri_pending", 32'(bus.pending), 32'b1010);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      checkOutput("pri_fire1_int", 32'(bus.INT), 32'd1);
      checkOutput("pri_fire1_entry", bus.entryPoint, 32'h110);
      checkOutput("pri_fire1_id", 32'(bus.active_id), 32'd1);
      checkOutput("pri_fire1_pending", 32'(bus.pending), 32'b1000);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      checkOutput("pri_service_int", 32'(bus.INT), 32'd0);
      checkOutput("pri_service_pending", 32'(bus.pending), 32'b1000);
      applyStimulus(4'b0000, 4'b0000, 1'b1);
      checkOutput("pri_done_idle", 32'(bus.in_service), 32'd0);
      checkOutput("pri_done_int", 32'(bus.INT), 32'd0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      checkOutput("pri_fire3_int", 32'(bus.INT), 32'd1);
      checkOutput("pri_fire3_entry", bus.entryPoint, 32'h130);
      checkOutput("pri_fire3_id", 32'(bus.active_id), 32'd3);
      checkOutput("pri_fire3_pending", 32'(bus.pending), 32'd0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      applyStimulus(4'b0000, 4'b0000, 1'b1);

      // Masked irq 0 stays pending, fires once unmasked.
      applyStimulus(4'b0001, 4'b0001, 1'b0);
      checkOutput("mask_pending", 32'(bus.pending), 32'b0001);
      checkOutput("mask_int", 32'(bus.INT), 32'd0);
      applyStimulus(4'b0001, 4'b0001, 1'b0);
      checkOutput("mask_hold_int", 32'(bus.INT), 32'd0);
      checkOutput("mask_hold_pending", 32'(bus.pending), 32'b0001);
      checkOutput("mask_hold_idle", 32'(bus.in_service), 32'd0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      checkOutput("unmask_int", 32'(bus.INT), 32'd1);
      checkOutput("unmask_entry", bus.entryPoint, 32'h100);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      applyStimulus(4'b0000, 4'b0000, 1'b1);

      // Level held high is one request; done in IDLE and FIRE is ignored.
      applyStimulus(4'b0001, 4'b0000, 1'b0);
      checkOutput("level_pending", 32'(bus.pending), 32'b0001);
      applyStimulus(4'b0001, 4'b0000, 1'b1);
      checkOutput("level_fire_int", 32'(bus.INT), 32'd1);
      applyStimulus(4'b0001, 4'b0000, 1'b1);
      checkOutput("done_in_fire_ignored", 32'(bus.in_service), 32'd1);
      repeat (7) applyStimulus(4'b0001, 4'b0000, 1'b0);
      checkOutput("level_single_pending", 32'(bus.pending), 32'd0);
      checkOutput("level_single_int", 32'(bus.INT), 32'd0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      applyStimulus(4'b0001, 4'b0000, 1'b0);
      checkOutput("relatch_pending", 32'(bus.pending), 32'b0001);
      checkOutput("relatch_in_service", 32'(bus.in_service), 32'd1);
      applyStimulus(4'b0001, 4'b0000, 1'b1);
      checkOutput("relatch_done", 32'(bus.in_service), 32'd0);
      applyStimulus(4'b0001, 4'b0000, 1'b0);
      checkOutput("relatch_fire_entry", bus.entryPoint, 32'h100);
      checkOutput("relatch_fire_int", 32'(bus.INT), 32'd1);
      applyStimulus(4'b0001, 4'b0000, 1'b0);

      // Reset during SERVICE with irq 3 pending.
      applyStimulus(4'b1001, 4'b0000, 1'b0);
      checkOutput("pre_rst_pending", 32'(bus.pending), 32'b1000);
      checkOutput("pre_rst_service", 32'(bus.in_service), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_int", 32'(bus.INT), 32'd1);
      checkOutput("mid_rst_entry", bus.entryPoint, 32'h28);
      checkOutput("mid_rst_pending", 32'(bus.pending), 32'd0);
      checkOutput("mid_rst_in_service", 32'(bus.in_service), 32'd0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      rst = 1'b0;
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      checkOutput("post_rst_int", 32'(bus.INT), 32'd0);
      checkOutput("post_rst_pending", 32'(bus.pending), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
